// File: rtl/fpm_pkg.sv
// Shared constants for the single-precision multiply sequencer: FSM encoding,
// IEEE-754 special values and flag bit positions.
package fpm_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_NORM  = 3'd4;
  localparam logic [2:0] ST_ROUND = 3'd5;
  localparam logic [2:0] ST_OUT   = 3'd6;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  localparam int BIAS_DEFAULT    = 127;
  localparam int TIMEOUT_DEFAULT = 64;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic logic [3:0] mk_flags(input logic invalid, input logic overflow,
                                          input logic underflow, input logic inexact);
    logic [3:0] f;
    f                 = '0;
    f[FLAG_INVALID]   = invalid;
    f[FLAG_OVERFLOW]  = overflow;
    f[FLAG_UNDERFLOW] = underflow;
    f[FLAG_INEXACT]   = inexact;
    return f;
  endfunction

endpackage

// File: rtl/fpm_special_decode.sv
// Combinational classification of an operand pair into NaN / infinity / zero
// results, with the packed special result for each class.
module fpm_special_decode
  import fpm_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  output logic                  is_nan,
  output logic                  is_inf,
  output logic                  is_zero,
  output logic [EXP_W+FRAC_W:0] special_result,
  output logic                  invalid
);

  localparam int W = EXP_W + FRAC_W + 1;

  logic a_emax, b_emax, a_ezero, b_ezero, a_fzero, b_fzero, sign;

  assign a_emax  = &a[W-2 -: EXP_W];
  assign b_emax  = &b[W-2 -: EXP_W];
  assign a_ezero = ~|a[W-2 -: EXP_W];
  assign b_ezero = ~|b[W-2 -: EXP_W];
  assign a_fzero = ~|a[FRAC_W-1:0];
  assign b_fzero = ~|b[FRAC_W-1:0];
  assign sign    = a[W-1] ^ b[W-1];

  // Only a true zero makes inf x 0 invalid; a denormal is finite nonzero, so
  // inf x denormal is infinity and the flush-to-zero rule never reaches it.
  assign is_nan  = (a_emax & ~a_fzero) | (b_emax & ~b_fzero) |
                   (a_emax & b_ezero & b_fzero) | (b_emax & a_ezero & a_fzero);
  assign is_inf  = ~is_nan & (a_emax | b_emax);
  assign is_zero = ~is_nan & ~is_inf & (a_ezero | b_ezero);
  assign invalid = is_nan;

  always_comb begin
    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    special_result = {sign, {(W-1){1'b0}}};
    if (is_nan)      special_result = QNAN;
    else if (is_inf) special_result = {sign, EXP_MAX, {FRAC_W{1'b0}}};
  end

endmodule

// File: rtl/fpm_sequencer.sv
// IEEE-754 single-precision multiply sequencer: operand handshake, special-case
// decode, Booth core start/done sequencing, normalize, round-to-nearest-even, pack.
module fpm_sequencer
  import fpm_pkg::*;
#(
  parameter int EXP_W   = 8,
  parameter int FRAC_W  = 23,
  parameter int BIAS    = BIAS_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   a,
  input  logic [EXP_W+FRAC_W:0]   b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic [3:0]              flags,
  output logic                    mul_start,
  output logic [FRAC_W:0]         mul_mcand,
  output logic [FRAC_W:0]         mul_mplier,
  input  logic                    mul_done,
  input  logic [2*FRAC_W+1:0]     mul_product
);

  localparam int W  = EXP_W + FRAC_W + 1;
  localparam int MW = FRAC_W + 1;
  localparam int PW = 2 * MW;
  localparam int XW = EXP_W + 2;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic signed [XW-1:0] BIAS_X   = XW'(BIAS);
  localparam logic signed [XW-1:0] EXP_OVF  = XW'((1 << EXP_W) - 1);
  localparam logic [CW-1:0]        CNT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]              state;
  logic [W-1:0]            a_r, b_r;
  logic                    sign_r;
  logic signed [XW-1:0]    exp_r;
  logic [CW-1:0]           cnt;
  logic [PW-1:0]           prod_r;
  logic [FRAC_W-1:0]       mant_r;
  logic                    guard_r, sticky_r;
  logic [W-1:0]            result_r;
  logic [3:0]              flags_r;
  logic [MW-1:0]           mcand_r, mplier_r;

  logic                    dec_nan, dec_inf, dec_zero, dec_invalid;
  logic [W-1:0]            dec_result;

  fpm_special_decode #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_decode (
    .a              (a_r),
    .b              (b_r),
    .is_nan         (dec_nan),
    .is_inf         (dec_inf),
    .is_zero        (dec_zero),
    .special_result (dec_result),
    .invalid        (dec_invalid)
  );

  // Round-to-nearest-even; the top bit of mant_inc is the carry into the exponent.
  logic                 round_up, inexact;
  logic [MW-1:0]        mant_inc;
  logic signed [XW-1:0] exp_fin;

  assign round_up = guard_r & (sticky_r | mant_r[0]);
  assign inexact  = guard_r | sticky_r;
  assign mant_inc = {1'b0, mant_r} + MW'(round_up);
  assign exp_fin  = exp_r + {{(XW-1){1'b0}}, mant_inc[MW-1]};

  assign in_ready   = (state == ST_IDLE);
  assign out_valid  = (state == ST_OUT);
  assign mul_start  = (state == ST_START);
  assign mul_mcand  = mcand_r;
  assign mul_mplier = mplier_r;
  assign result     = result_r;
  assign flags      = flags_r;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state    <= ST_IDLE;
      a_r      <= '0;
      b_r      <= '0;
      sign_r   <= 1'b0;
      exp_r    <= '0;
      cnt      <= '0;
      prod_r   <= '0;
      mant_r   <= '0;
      guard_r  <= 1'b0;
      sticky_r <= 1'b0;
      result_r <= '0;
      flags_r  <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= b;
          state <= ST_CHECK;
        end
        ST_CHECK: begin
          sign_r <= a_r[W-1] ^ b_r[W-1];
          if (dec_nan | dec_inf | dec_zero) begin
            result_r <= dec_result;
            flags_r  <= mk_flags(dec_invalid, 1'b0, 1'b0, 1'b0);
            state    <= ST_OUT;
          end else begin
            exp_r    <= XW'(a_r[W-2 -: EXP_W]) + XW'(b_r[W-2 -: EXP_W]) - BIAS_X;
            mcand_r  <= {1'b1, a_r[FRAC_W-1:0]};
            mplier_r <= {1'b1, b_r[FRAC_W-1:0]};
            state    <= ST_START;
          end
        end
        ST_START: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt + CW'(1);
          if (mul_done) begin
            prod_r <= mul_product;
            state  <= ST_NORM;
          end else if (cnt == CNT_LAST) begin
            result_r <= QNAN;
            flags_r  <= mk_flags(1'b1, 1'b0, 1'b0, 1'b0);
            state    <= ST_OUT;
          end
        end
        ST_NORM: begin
          if (prod_r[PW-1]) begin
            mant_r   <= prod_r[PW-2 -: FRAC_W];
            guard_r  <= prod_r[PW-2-FRAC_W];
            sticky_r <= |prod_r[PW-3-FRAC_W:0];
            exp_r    <= exp_r + XW'(1);
          end else begin
            mant_r   <= prod_r[PW-3 -: FRAC_W];
            guard_r  <= prod_r[PW-3-FRAC_W];
            sticky_r <= |prod_r[PW-4-FRAC_W:0];
          end
          state <= ST_ROUND;
        end
        ST_ROUND: begin
          if (exp_fin >= EXP_OVF) begin
            result_r <= {sign_r, EXP_MAX, {FRAC_W{1'b0}}};
            flags_r  <= mk_flags(1'b0, 1'b1, 1'b0, inexact);
          end else if (exp_fin[XW-1] || exp_fin == '0) begin
            result_r <= {sign_r, {(W-1){1'b0}}};
            flags_r  <= mk_flags(1'b0, 1'b0, 1'b1, inexact);
          end else begin
            result_r <= {sign_r, exp_fin[EXP_W-1:0], mant_inc[FRAC_W-1:0]};
            flags_r  <= mk_flags(1'b0, 1'b0, 1'b0, inexact);
          end
          state <= ST_OUT;
        end
        ST_OUT: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpm_sequencer.sv
// Self-checking bench for fpm_sequencer: behavioural Booth core responder plus an
// arithmetic reference model of single-precision multiply with flush-to-zero.
`timescale 1ns/1ps
module tb_fpm_sequencer;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready, mul_done;
  logic [31:0] a, b;
  logic        in_ready, out_valid, mul_start;
  logic [31:0] result;
  logic [3:0]  flags;
  logic [23:0] mul_mcand, mul_mplier;
  logic [47:0] mul_product;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          core_lat  = 24;
  bit          core_en   = 1'b1;
  int          starts    = 0;
  int          start_cyc = -1;
  int          done_cyc  = -1;
  bit          pend      = 1'b0;
  int          pend_cnt  = 0;
  logic [47:0] pend_p;

  fpm_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .flags       (flags),
    .mul_start   (mul_start),
    .mul_mcand   (mul_mcand),
    .mul_mplier  (mul_mplier),
    .mul_done    (mul_done),
    .mul_product (mul_product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural mantissa core: done arrives core_lat cycles after the start pulse;
  // the product bus carries garbage whenever done is low.
  initial begin
    mul_done    = 1'b0;
    mul_product = '0;
    forever begin
      @(posedge clk); #1;
      mul_done    = 1'b0;
      mul_product = {16'($urandom), 32'($urandom)};
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mul_done    = 1'b1;
          mul_product = pend_p;
          pend        = 1'b0;
          done_cyc    = cyc;
        end
      end
      if (mul_start) begin
        starts++;
        start_cyc = cyc;
        if (core_en) begin
          pend     = 1'b1;
          pend_cnt = core_lat;
          pend_p   = 48'(mul_mcand) * 48'(mul_mplier);
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Reference: exact integer significand product, rounded by comparing the
  // discarded remainder against one half ulp.
  function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [3:0] f);
    bit     s, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    int     ex, ey, e, sh;
    longint mx, my, p, q, rem, half;
    s      = x[31] ^ y[31];
    ex     = int'(x[30:23]);
    ey     = int'(y[30:23]);
    x_nan  = (ex == 255) && (x[22:0] != 0);
    y_nan  = (ey == 255) && (y[22:0] != 0);
    x_inf  = (ex == 255) && (x[22:0] == 0);
    y_inf  = (ey == 255) && (y[22:0] == 0);
    x_zero = (ex == 0) && (x[22:0] == 0);
    y_zero = (ey == 0) && (y[22:0] == 0);
    f = 4'b0000;
    r = 32'h0;
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) begin
      r = 32'h7FC00000;
      f = 4'b1000;
    end else if (x_inf || y_inf) begin
      r = {s, 8'hFF, 23'h0};
    end else if (ex == 0 || ey == 0) begin
      r = {s, 31'h0};
    end else begin
      mx = longint'(x[22:0]) + (longint'(1) << 23);
      my = longint'(y[22:0]) + (longint'(1) << 23);
      p  = mx * my;
      e  = ex + ey - 127;
      if (p >= (longint'(1) << 47)) begin sh = 24; e++; end
      else sh = 23;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == (longint'(1) << 24)) begin q = q >> 1; e++; end
      if (rem != 0) f[0] = 1'b1;
      if (e >= 255) begin r = {s, 8'hFF, 23'h0}; f[2] = 1'b1; end
      else if (e <= 0) begin r = {s, 31'h0}; f[1] = 1'b1; end
      else r = {s, 8'(e), 23'(q)};
    end
  endfunction

  function automatic logic [31:0] gen_operand();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0: begin v[30:23] = 8'h00; if ($urandom_range(0, 1) == 1) v[22:0] = '0; end
      1: begin v[30:23] = 8'hFF; v[22:0] = '0; end
      2: begin v[30:23] = 8'hFF; v[0] = 1'b1; end
      3, 4: v[30:23] = 8'(228 + $urandom_range(0, 26));
      5, 6: v[30:23] = 8'(1 + $urandom_range(0, 24));
      7: begin v[30:23] = 8'(110 + $urandom_range(0, 30)); v[22:0] = '1; end
      default: v[30:23] = 8'(100 + $urandom_range(0, 54));
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input int hold,
                       output logic [31:0] res, output logic [3:0] fl,
                       output int t_acc, output int t_out);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 400) begin tick(); n++; end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL accept_wait: in_ready=%b required 1", in_ready); end
    a = av; b = bv; in_valid = 1'b1; t_acc = cyc;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 400) begin tick(); n++; end
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL out_wait: out_valid=%b required 1", out_valid); end
    t_out = cyc; res = result; fl = flags;
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
    total++; if (flags !== 4'h0) begin bad++; $display("FAIL reset_flags: got %b want 0", flags); end
    total++; if (mul_start !== 1'b0) begin bad++; $display("FAIL reset_mul_start: got %b want 0", mul_start); end
    total++; if (mul_mcand !== 24'h0 || mul_mplier !== 24'h0)
      begin bad++; $display("FAIL reset_operands: got %h/%h want 0/0", mul_mcand, mul_mplier); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] res; logic [3:0] fl; int ta, to, s0;
    core_lat = 24; s0 = starts;
    do_op(32'h40400000, 32'h40000000, 0, res, fl, ta, to);
    total++; if (res !== 32'h40C00000) begin bad++; $display("FAIL basic_result: got %h want 40c00000", res); end
    total++; if (fl !== 4'b0000) begin bad++; $display("FAIL basic_flags: got %b want 0000", fl); end
    total++; if (starts - s0 !== 1) begin bad++; $display("FAIL basic_start_pulses: got %0d want 1", starts - s0); end
    total++; if (start_cyc - ta !== 2) begin bad++; $display("FAIL basic_start_latency: got %0d want 2", start_cyc - ta); end
    total++; if (to - done_cyc !== 3) begin bad++; $display("FAIL basic_done_to_out: got %0d want 3", to - done_cyc); end
  endtask

  task automatic test_norm_hi();
    logic [31:0] res; logic [3:0] fl; int ta, to;
    core_lat = 7;
    do_op(32'h3FC00000, 32'h3FC00000, 1, res, fl, ta, to);
    total++; if (res !== 32'h40100000) begin bad++; $display("FAIL norm_hi_result: got %h want 40100000", res); end
    total++; if (fl !== 4'b0000) begin bad++; $display("FAIL norm_hi_flags: got %b want 0000", fl); end
  endtask

  task automatic test_special();
    logic [31:0] res; logic [3:0] fl; int ta, to, s0;
    s0 = starts;
    do_op(32'h7F800000, 32'h00000000, 0, res, fl, ta, to);
    total++; if (res !== 32'h7FC00000) begin bad++; $display("FAIL special_result: got %h want 7fc00000", res); end
    total++; if (fl !== 4'b1000) begin bad++; $display("FAIL special_flags: got %b want 1000", fl); end
    total++; if (to - ta !== 2) begin bad++; $display("FAIL special_latency: got %0d want 2", to - ta); end
    total++; if (starts !== s0) begin bad++; $display("FAIL special_no_start: got %0d pulses want 0", starts - s0); end
  endtask

  task automatic test_overflow();
    logic [31:0] res; logic [3:0] fl; int ta, to;
    core_lat = 3;
    do_op(32'h7F000000, 32'h40000000, 0, res, fl, ta, to);
    total++; if (res !== 32'h7F800000) begin bad++; $display("FAIL overflow_result: got %h want 7f800000", res); end
    total++; if (fl !== 4'b0100) begin bad++; $display("FAIL overflow_flags: got %b want 0100", fl); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a1, b1, a2, b2, e1, e2, res; logic [3:0] f1, f2, fl; int n, ta, to;
    a1 = 32'h3F9E0651; b1 = 32'h40490FDB; a2 = 32'hC0A00001; b2 = 32'h3EAAAAAB;
    ref_mul(a1, b1, e1, f1);
    ref_mul(a2, b2, e2, f2);
    core_lat = 5;
    a = a1; b = b1; in_valid = 1'b1;
    tick();
    a = a2; b = b2;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin tick(); n++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_wait: out_valid=%b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (result !== e1 || flags !== f1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold[%0d]: result=%h flags=%b in_ready=%b out_valid=%b want %h %b 0 1",
                 i, result, flags, in_ready, out_valid, e1, f1);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    tick();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin tick(); n++; end
    res = result; fl = flags; ta = 0; to = 0;
    total++; if (res !== e2 || fl !== f2)
      begin bad++; $display("FAIL bp_second: result=%h flags=%b want %h %b", res, fl, e2, f2); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_timeout();
    logic [31:0] res; logic [3:0] fl; int ta, to;
    core_en = 1'b0;
    do_op(32'h40400000, 32'h40400000, 0, res, fl, ta, to);
    core_en = 1'b1;
    total++; if (res !== 32'h7FC00000) begin bad++; $display("FAIL timeout_result: got %h want 7fc00000", res); end
    total++; if (fl !== 4'b1000) begin bad++; $display("FAIL timeout_flags: got %b want 1000", fl); end
    total++; if (to - start_cyc < TIMEOUT || to - start_cyc > TIMEOUT + 2)
      begin bad++; $display("FAIL timeout_latency: got %0d want %0d..%0d", to - start_cyc, TIMEOUT, TIMEOUT + 2); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    core_lat = 20;
    a = 32'h40400000; b = 32'h40000000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL rst_mid_result: got %h want 0", result); end
    seen = 1'b0;
    repeat (40) begin tick(); if (out_valid === 1'b1) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_stale: out_valid seen=%b want 0", seen); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_idle: in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_random();
    logic [31:0] av, bv, er, res; logic [3:0] ef, fl; int ta, to;
    for (int i = 0; i < 200; i++) begin
      av = gen_operand();
      bv = gen_operand();
      core_lat = $urandom_range(1, 30);
      ref_mul(av, bv, er, ef);
      do_op(av, bv, $urandom_range(0, 3), res, fl, ta, to);
      total++;
      if (res !== er || fl !== ef) begin
        bad++;
        $display("FAIL random[%0d] a=%h b=%h: result=%h flags=%b want %h %b", i, av, bv, res, fl, er, ef);
      end
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    test_reset();
    test_basic();
    test_norm_hi();
    test_special();
    test_overflow();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpm_sequencer.md
Name: fpm_sequencer

Overview:
Top-level sequencer for the 32-bit IEEE-754 single-precision multiplier. It accepts operand pairs over a valid/ready handshake and decodes special cases. It sequences the iterative Booth mantissa core through a start/done handshake, then normalizes, rounds (round-to-nearest-even) and packs the result. It sits between the operand source and the existing Booth mantissa datapath/controller.

Parameters:
EXP_W, 8, exponent field width
FRAC_W, 23, fraction field width (mantissa core width = FRAC_W+1)
BIAS, 127, exponent bias
TIMEOUT, 64, max cycles waited for mul_done before abort

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
a  in  32  operand A, IEEE-754 single
b  in  32  operand B, IEEE-754 single
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  32  packed product
flags  out  4  {invalid, overflow, underflow, inexact}, valid with out_valid
mul_start  out  1  one-cycle start pulse to mantissa core
mul_mcand  out  24  multiplicand {1,frac_a}
mul_mplier  out  24  multiplier {1,frac_b}
mul_done  in  1  mantissa core finished
mul_product  in  48  unsigned mantissa product, valid while mul_done=1

Behaviour:
- Reset: clk is the only clock. reset=0 sampled on a clk edge forces IDLE from any state. Outputs after reset: in_ready=1, out_valid=0, result=0, flags=0, mul_start=0, mul_mcand=0, mul_mplier=0, timeout counter=0.
- A reset during any state aborts the operation; the in-flight operation is discarded and never appears at the output.
- FSM states: IDLE, CHECK, START, WAIT, NORM, ROUND, OUT.
- IDLE: in_ready=1. On in_valid&in_ready, register a and b and go to CHECK. in_ready is 0 in every other state.
- CHECK: sign = sa^sb. Special cases are checked in this priority order:
  - NaN operand (exp all-ones, frac≠0) or inf×0: result=0x7FC00000, invalid=1.
  - Inf × finite nonzero: result = {sign, 0xFF, 0}.
  - Zero or denormal operand (exp=0): flushed to zero; result = {sign, 0}.
  - Any special case goes directly to OUT.
  - Otherwise: exp_sum = ea + eb − BIAS, computed as a 10-bit signed value. Go to START.
- START: mul_start=1 for exactly this cycle. mul_mcand and mul_mplier are driven, then held constant until WAIT exits. Go to WAIT.
- WAIT: the counter increments each cycle.
  - mul_done=1: capture mul_product, go to NORM.
  - Counter reaches TIMEOUT: result=0x7FC00000, invalid=1, go to OUT.
  - mul_done in any other state is ignored.
- NORM:
  - If p[47]=1: mant=p[46:24], guard=p[23], sticky=|p[22:0], exp=exp_sum+1.
  - Else: mant=p[45:23], guard=p[22], sticky=|p[21:0], exp=exp_sum.
- ROUND:
  - Increment mant if guard&(sticky|mant[0]). A carry out of mant gives mant=0, exp+1.
  - inexact = guard|sticky.
  - exp ≥ 255: result = {sign, 0xFF, 0}, overflow=1.
  - exp ≤ 0: result = {sign, 0}, underflow=1 (flush).
  - Else result = {sign, exp[7:0], mant}.
  - Go to OUT.
- OUT: out_valid=1. result and flags are held stable while out_ready=0. On out_ready=1, go to IDLE. out_valid drops the next cycle and in_ready rises the next cycle.
- Latency, accept at cycle T:
  - Special case: out_valid at T+2.
  - Normal: mul_start at T+2. If mul_done is sampled at cycle D, out_valid is at D+3.
- Throughput: one operation in flight. No new accept until the result is consumed.

Decomposition:
- Package fpm_pkg holds:
  - state enum/encoding;
  - constants QNAN=32'h7FC00000, EXP_MAX=8'hFF, BIAS, TIMEOUT default;
  - flag bit indices.
- One natural sub-module: fpm_special_decode. It is combinational: a, b in; is_nan, is_inf, is_zero, special_result, invalid out.
- Normalization and rounding stay in the sequencer.

Test Plan:
- a=0x40400000 (3.0), b=0x40000000 (2.0); behavioral core asserts done 24 cycles after start → result=0x40C00000, flags=0, mul_start exactly one pulse.
- a=b=0x3FC00000 (1.5) → p[47]=1 normalization path, result=0x40100000, flags=0.
- a=0x7F800000 (inf), b=0x00000000 → result=0x7FC00000, invalid=1, out_valid at T+2, mul_start never asserted.
- a=0x7F000000, b=0x40000000 → result=0x7F800000, overflow=1, inexact=0.
- Normal op with out_ready=0 for 5 cycles while in_valid=1 with new operands → result/flags stable, in_ready=0, second pair accepted only after the out_ready handshake.
- reset=0 for one cycle during WAIT, then late mul_done → next cycle IDLE, in_ready=1, out_valid=0, stale product never output.
